dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between NUM_CORES matrix-multiply cores and the external load/readout port.

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin DMEM arbiter between matrix cores and the external load/readout port
// Cores share the single-port memory one access per cycle; external access owns it after a one-cycle switch-over.
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [1:0]                ext_mode,
  input  logic [ADDR_W-1:0]         ext_addr,
  input  logic [DATA_W-1:0]         ext_wdata,
  input  logic                      ext_we,
  output logic                      ext_ready,
  input  logic [NUM_CORES-1:0]      core_req,
  input  logic [NUM_CORES-1:0]      core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]      core_gnt,
  output logic [NUM_CORES-1:0]      core_rvalid,
  output logic [DATA_W-1:0]         core_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_CORE   = 2'd0;
  localparam logic [1:0] S_SWITCH = 2'd1;
  localparam logic [1:0] S_EXT    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [NUM_CORES-1:0] gnt;
  logic [PTR_W-1:0]     sel;
  logic                 found;
  logic                 arb_en;

  assign arb_en = !RESET && (state_q == S_CORE) && (ext_mode == 2'd0);

  // Scan downward so the last hit, i.e. the first requester at or above rr_ptr, wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_req[(int'(rr_ptr_q) + i) % NUM_CORES]) begin
        sel   = PTR_W'((int'(rr_ptr_q) + i) % NUM_CORES);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt       = '0;
    rvalid_d  = '0;
    rr_ptr_d  = rr_ptr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (RESET) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (arb_en && found) begin
      gnt[sel]      = 1'b1;
      mem_addr      = core_addr[int'(sel)*ADDR_W +: ADDR_W];
      mem_wdata     = core_wdata[int'(sel)*DATA_W +: DATA_W];
      mem_we        = core_we[sel];
      rvalid_d[sel] = !core_we[sel];
      rr_ptr_d      = (sel == PTR_W'(NUM_CORES - 1)) ? '0 : sel + PTR_W'(1);
    end else if (state_q == S_EXT) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we && (ext_mode == 2'd1);
    end
  end

  always_comb begin
    state_d = S_CORE;
    case (state_q)
      S_CORE:   state_d = (ext_mode != 2'd0) ? S_SWITCH : S_CORE;
      S_SWITCH: state_d = (ext_mode != 2'd0) ? S_EXT : S_CORE;
      S_EXT:    state_d = (ext_mode == 2'd0) ? S_SWITCH : S_EXT;
      default:  state_d = S_CORE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_CORE;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
    end
  end

  // Outputs are forced to their reset values while RESET is held, dropping any owed rvalid.
  assign core_gnt    = gnt;
  assign core_rvalid = RESET ? '0 : rvalid_q;
  assign ext_ready   = !RESET && (state_q == S_EXT);
  assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven and scoreboard bench for dmem_arbiter
// Drives one cycle per step, checks combinational outputs mid-cycle and read data through a queue.
module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            RESET;
  logic [1:0]      ext_mode;
  logic [AW-1:0]   ext_addr;
  logic [DW-1:0]   ext_wdata;
  logic            ext_we;
  logic            ext_ready;
  logic [N-1:0]    core_req, core_we, core_gnt, core_rvalid;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0]   core_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .RESET(RESET), .ext_mode(ext_mode), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_ready(ext_ready),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // DMEM: registered read, every word initially holds its own address.
  logic [15:0] mem [0:1023];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'(i);
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[9:0]];
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] we;
    logic [1:0] mode;
    logic [3:0] gnt;
    logic       mwe;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic [3:0]  vec;
    logic [15:0] data;
  } sb_t;

  vec_t        tbl [0:7];
  sb_t         sbq [$];
  logic [15:0] exp_mem [0:1023];
  logic [15:0] caddr [0:N-1];
  logic [15:0] cwdata [0:N-1];
  logic        rd_pend;
  logic [15:0] rd_exp;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] we,
                     input logic [1:0] mode, input logic ewe, input logic [15:0] eaddr,
                     input logic [15:0] edata, input logic [3:0] egnt, input logic emwe,
                     input logic erdy, input string nm);
    sb_t e;
    @(posedge clk);
    #1;
    RESET     = rst;
    core_req  = req;
    core_we   = we;
    ext_mode  = mode;
    ext_we    = ewe;
    ext_addr  = eaddr;
    ext_wdata = edata;
    for (int i = 0; i < N; i++) begin
      core_addr[i*AW +: AW]  = caddr[i];
      core_wdata[i*DW +: DW] = cwdata[i];
    end
    #2;
    chk({nm, ".gnt"}, 32'(core_gnt), 32'(egnt));
    chk({nm, ".mem_we"}, 32'(mem_we), 32'(emwe));
    chk({nm, ".ext_ready"}, 32'(ext_ready), 32'(erdy));

    e.vec  = '0;
    e.data = '0;
    if (rst) sbq.delete();
    else if (sbq.size() > 0) e = sbq.pop_front();
    chk({nm, ".rvalid"}, 32'(core_rvalid), 32'(e.vec));
    if (e.vec != 4'd0) chk({nm, ".rdata"}, 32'(core_rdata), 32'(e.data));

    if (rd_pend) chk({nm, ".ext_rdata"}, 32'(core_rdata), 32'(rd_exp));
    rd_pend = 1'b0;

    if (rst) begin
      chk({nm, ".rst_addr"}, 32'(mem_addr), 32'd0);
      chk({nm, ".rst_wdata"}, 32'(mem_wdata), 32'd0);
    end

    for (int k = 0; k < N; k++) begin
      if (egnt[k]) begin
        chk({nm, ".core_addr"}, 32'(mem_addr), 32'(caddr[k]));
        if (we[k]) begin
          chk({nm, ".core_wdata"}, 32'(mem_wdata), 32'(cwdata[k]));
          exp_mem[caddr[k][9:0]] = cwdata[k];
        end else begin
          sbq.push_back('{egnt, exp_mem[caddr[k][9:0]]});
        end
      end
    end

    if (erdy && mode != 2'd0) begin
      chk({nm, ".ext_addr"}, 32'(mem_addr), 32'(eaddr));
      if (emwe) begin
        chk({nm, ".ext_wdata"}, 32'(mem_wdata), 32'(edata));
        exp_mem[eaddr[9:0]] = edata;
      end
      if (mode[1]) begin
        rd_pend = 1'b1;
        rd_exp  = exp_mem[eaddr[9:0]];
      end
    end
  endtask

  initial begin
    RESET = 1'b1; mem_clr = 1'b1; rd_pend = 1'b0; rd_exp = '0;
    ext_mode = '0; ext_addr = '0; ext_wdata = '0; ext_we = 1'b0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 16'(i);
    for (int i = 0; i < N; i++) begin
      caddr[i]  = 16'h0010 + 16'(i);
      cwdata[i] = 16'h1232 + 16'(i);
    end

    //            rst   req    we     mode  gnt    mwe   rdy
    tbl[0] = '{1'b1, 4'hF, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'hF, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 4'h0, 2'd0, 4'h1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 4'hF, 4'h0, 2'd0, 4'h2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'hF, 4'h0, 2'd0, 4'h4, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 4'hF, 4'h0, 2'd0, 4'h8, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 4'hF, 4'h0, 2'd0, 4'h1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;

    for (int i = 0; i < 8; i++)
      cyc(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].mode, 1'b0, 16'h0, 16'h0,
          tbl[i].gnt, tbl[i].mwe, tbl[i].rdy, $sformatf("tbl%0d", i));

    // Lone write from core 2, then 1 and 3 compete with rr_ptr at 3.
    caddr[2] = 16'h0010;
    cyc(1'b0, 4'b0100, 4'b0100, 2'd0, 1'b0, 16'h0, 16'h0, 4'b0100, 1'b1, 1'b0, "t3_wr");
    caddr[2] = 16'h0012;
    cyc(1'b0, 4'b1010, 4'b0000, 2'd0, 1'b0, 16'h0, 16'h0, 4'b1000, 1'b0, 1'b0, "t3_rr_a");
    cyc(1'b0, 4'b1010, 4'b0000, 2'd0, 1'b0, 16'h0, 16'h0, 4'b0010, 1'b0, 1'b0, "t3_rr_b");

    // Switch to external load and write addresses 0..9.
    cyc(1'b0, 4'hF, 4'h0, 2'd1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t4_exit");
    cyc(1'b0, 4'hF, 4'h0, 2'd1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t4_switch");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 4'hF, 4'h0, 2'd1, 1'b1, 16'(i), 16'hA500 + 16'(i), 4'h0, 1'b1, 1'b1,
          $sformatf("t4_wr%0d", i));

    // Readout of the loaded words and of untouched address 997; ext_we must be ignored.
    for (int k = 0; k < 11; k++)
      cyc(1'b0, 4'hF, 4'h0, 2'd2, 1'b1, (k < 10) ? 16'(k) : 16'd997, 16'hFFFF,
          4'h0, 1'b0, 1'b1, $sformatf("t5_rd%0d", k));
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b1, 16'd997, 16'hFFFF, 4'h0, 1'b0, 1'b1, "t5_exit");
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t5_switch");
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'b0100, 1'b0, 1'b0, "t5_resume2");
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'b1000, 1'b0, 1'b0, "t5_resume3");
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'b0001, 1'b0, 1'b0, "t5_resume0");

    // Reset inside EXT, then reset one cycle after a read grant.
    cyc(1'b0, 4'hF, 4'h0, 2'd1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t6_exit");
    cyc(1'b0, 4'hF, 4'h0, 2'd1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t6_switch");
    cyc(1'b0, 4'hF, 4'h0, 2'd1, 1'b1, 16'd20, 16'h5555, 4'h0, 1'b1, 1'b1, "t6_ext");
    cyc(1'b1, 4'hF, 4'h0, 2'd1, 1'b1, 16'd21, 16'h6666, 4'h0, 1'b0, 1'b0, "t6_rst_ext");
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'b0001, 1'b0, 1'b0, "t6_after_rst");
    cyc(1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t6_rst_rd");
    cyc(1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'b0001, 1'b0, 1'b0, "t6_rr_zero");
    cyc(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t6_idle0");
    cyc(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, "t6_idle1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
